// File: rtl/exec_unit_scheduler.sv
// exec_unit_scheduler: multicycle execute sequencer routing one instruction at a time to ALU, MDU or FPU
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   issue_valid/issue_ready  instruction handshake with the decode/register-read stage
//   is_mdu, is_fpu           target select (FPU has priority over MDU; neither selects the ALU)
//   fp_dest, reg_write, rd   destination descriptor latched on acceptance
//   mdu_start/mdu_done       MDU launch pulse and single-cycle completion
//   fpu_start/fpu_done       FPU launch pulse and single-cycle completion
//   wb_valid/sel/we/fp/rd    one-cycle writeback command to the writeback mux
//   stall                    front-end hold while an instruction is in flight
//   timeout_err              one-cycle abort pulse (SCHED_TIMEOUT_EN builds only)
//
// Build option: define SCHED_TIMEOUT_EN to abort a WAIT state after TIMEOUT_CYCLES cycles.
module exec_unit_scheduler #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic       is_mdu,
    input  logic       is_fpu,
    input  logic       fp_dest,
    input  logic       reg_write,
    input  logic [4:0] rd,
    output logic       mdu_start,
    input  logic       mdu_done,
    output logic       fpu_start,
    input  logic       fpu_done,
    output logic       wb_valid,
    output logic [1:0] wb_sel,
    output logic       wb_we,
    output logic       wb_fp,
    output logic [4:0] wb_rd,
    output logic       stall,
    output logic       timeout_err
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || (TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_bad_cfg
        $error("exec_unit_scheduler: TIMEOUT_CYCLES must be 2..65535 and below 2**CNT_W");
    end

    typedef enum logic [1:0] {IDLE, MDU_WAIT, FPU_WAIT, WB} state_t;

    state_t     r_state, w_next;
    logic [4:0] r_rd;
    logic [1:0] r_tgt;
    logic       r_fp, r_we;
    logic       r_mdu_start, r_fpu_start, r_wb_valid, r_wb_we, r_wb_fp, r_timeout;
    logic [1:0] r_wb_sel;
    logic [4:0] r_wb_rd;
    logic       w_acc, w_wait, w_done, w_to, w_we_in, w_to_wb;
    logic [1:0] w_tgt;

    assign issue_ready = (r_state == IDLE);
    assign stall       = (r_state != IDLE);
    assign w_acc       = issue_valid && issue_ready;
    assign w_tgt       = is_fpu ? 2'b10 : is_mdu ? 2'b01 : 2'b00;
    // Integer x0 is hardwired zero; FP f0 is a real register.
    assign w_we_in     = reg_write && (fp_dest || rd != 5'd0);
    assign w_wait      = (r_state == MDU_WAIT) || (r_state == FPU_WAIT);
    // Only the unit we launched may complete the instruction.
    assign w_done      = (r_state == MDU_WAIT && mdu_done) || (r_state == FPU_WAIT && fpu_done);
    assign w_to_wb     = (w_next == WB);

`ifdef SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_cnt;
    // The counter equals the number of done-less WAIT cycles already elapsed,
    // so hitting LAST here means this is the TIMEOUT_CYCLES-th such cycle.
    assign w_to = w_wait && !w_done && r_cnt == LAST;
    always_ff @(posedge clk) begin
        if (rst || w_acc)
            r_cnt <= '0;
        else if (w_wait && !w_done && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_to = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = !w_acc ? IDLE : is_fpu ? FPU_WAIT : is_mdu ? MDU_WAIT : WB;
            MDU_WAIT,
            FPU_WAIT: w_next = (w_done || w_to) ? WB : r_state;
            default:  w_next = IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rd        <= '0;
            r_tgt       <= '0;
            r_fp        <= 1'b0;
            r_we        <= 1'b0;
            r_mdu_start <= 1'b0;
            r_fpu_start <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_sel    <= '0;
            r_wb_we     <= 1'b0;
            r_wb_fp     <= 1'b0;
            r_wb_rd     <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_rd  <= rd;
                r_tgt <= w_tgt;
                r_fp  <= fp_dest;
                r_we  <= w_we_in;
            end
            r_mdu_start <= w_acc && w_next == MDU_WAIT;
            r_fpu_start <= w_acc && w_next == FPU_WAIT;
            r_wb_valid  <= w_to_wb;
            r_wb_sel    <= !w_to_wb ? 2'b00 : w_acc ? w_tgt : r_tgt;
            r_wb_we     <= w_to_wb && !w_to && (w_acc ? w_we_in : r_we);
            r_wb_fp     <= w_to_wb && (w_acc ? fp_dest : r_fp);
            r_wb_rd     <= !w_to_wb ? 5'd0 : w_acc ? rd : r_rd;
            r_timeout   <= w_to;
        end
    end

    assign mdu_start   = r_mdu_start;
    assign fpu_start   = r_fpu_start;
    assign wb_valid    = r_wb_valid;
    assign wb_sel      = r_wb_sel;
    assign wb_we       = r_wb_we;
    assign wb_fp       = r_wb_fp;
    assign wb_rd       = r_wb_rd;
    assign timeout_err = r_timeout;
endmodule

// File: tb/tb_exec_unit_scheduler.sv
// tb_exec_unit_scheduler: directed self-checking bench for exec_unit_scheduler
module tb_exec_unit_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0, is_mdu = 1'b0, is_fpu = 1'b0, fp_dest = 1'b0, reg_write = 1'b0;
    logic [4:0] rd = 5'd0;
    logic       mdu_done = 1'b0, fpu_done = 1'b0;
    logic       issue_ready, mdu_start, fpu_start, wb_valid, wb_we, wb_fp, stall, timeout_err;
    logic [1:0] wb_sel;
    logic [4:0] wb_rd;
    int         n_chk = 0, n_err = 0;

    exec_unit_scheduler #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .is_mdu(is_mdu), .is_fpu(is_fpu), .fp_dest(fp_dest), .reg_write(reg_write), .rd(rd),
        .mdu_start(mdu_start), .mdu_done(mdu_done), .fpu_start(fpu_start), .fpu_done(fpu_done),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_we(wb_we), .wb_fp(wb_fp), .wb_rd(wb_rd),
        .stall(stall), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in an IDLE cycle, advance to the next cycle and withdraw it.
    task automatic issue(input logic m, input logic f, input logic fp, input logic we, input logic [4:0] r);
        issue_valid = 1'b1; is_mdu = m; is_fpu = f; fp_dest = fp; reg_write = we; rd = r;
        step();
        issue_valid = 1'b0; is_mdu = 1'b0; is_fpu = 1'b0;
    endtask

    initial begin
        int st_n, go_n, wb_cyc, to_bad;
        logic to_s, we_s;
        logic [1:0] sel_s;

        step(); step();
        rst = 1'b0;
        chk("rst_ready", issue_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_starts", {mdu_start, fpu_start, timeout_err}, 0);
        chk("rst_wb_fields", {wb_sel, wb_we, wb_fp, wb_rd}, 0);

        // ALU: accept at cycle 0, writeback at cycle 1, ready again at cycle 2
        issue_valid = 1'b1; reg_write = 1'b1; rd = 5'd5;
        chk("alu_ready_c0", issue_ready, 1);
        step();
        issue_valid = 1'b0;
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_sel", wb_sel, 0);
        chk("alu_wb_rd", wb_rd, 5);
        chk("alu_wb_we", wb_we, 1);
        chk("alu_wb_fp", wb_fp, 0);
        chk("alu_stall_wb", stall, 1);
        chk("alu_ready_wb", issue_ready, 0);
        step();
        chk("alu_ready_c2", issue_ready, 1);
        chk("alu_wb_drop", wb_valid, 0);

        // Back-to-back ALU: issue_valid held, second op accepted two cycles later; x0 and no-write cases
        issue_valid = 1'b1; reg_write = 1'b1; rd = 5'd0;
        step();
        rd = 5'd4; reg_write = 1'b0;
        chk("alu_x0_we", wb_we, 0);
        chk("alu_x0_valid", wb_valid, 1);
        step();
        chk("b2b_ready", issue_ready, 1);
        step();
        issue_valid = 1'b0;
        chk("b2b_wb_rd", wb_rd, 4);
        chk("b2b_nowrite_we", wb_we, 0);
        step();

        // MDU: done three cycles after the start pulse, inputs wiggled while busy must be ignored
        issue(1'b1, 1'b0, 1'b0, 1'b1, 5'd7);
        st_n = 0; go_n = 0;
        for (int c = 1; c <= 5; c++) begin
            st_n += int'(stall);
            go_n += int'(mdu_start);
            if (c == 1) chk("mdu_start_c1", mdu_start, 1);
            issue_valid = (c == 2 || c == 3); is_fpu = (c == 2 || c == 3); rd = 5'd9;
            mdu_done = (c == 4);
            if (c == 5) begin
                chk("mdu_wb_valid", wb_valid, 1);
                chk("mdu_wb_sel", wb_sel, 1);
                chk("mdu_wb_rd", wb_rd, 7);
                chk("mdu_wb_we", wb_we, 1);
                chk("mdu_fpu_idle", fpu_start, 0);
            end else
                chk("mdu_no_early_wb", wb_valid, 0);
            if (c < 5) step();
        end
        issue_valid = 1'b0; is_fpu = 1'b0; mdu_done = 1'b0;
        chk("mdu_start_count", go_n, 1);
        chk("mdu_stall_count", st_n, 5);
        step();
        chk("mdu_idle_after", {issue_ready, stall, wb_valid}, 3'b100);

        // FPU zero latency: done in the start cycle, FP f0 is writable
        issue(1'b0, 1'b1, 1'b1, 1'b1, 5'd0);
        chk("fpu0_start", fpu_start, 1);
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("fpu0_wb", {wb_valid, wb_sel, wb_fp, wb_we, wb_rd}, {1'b1, 2'b10, 1'b1, 1'b1, 5'd0});
        chk("fpu0_start_drop", fpu_start, 0);
        step();
        chk("fpu0_ready", issue_ready, 1);

        // Priority and x0: both targets set picks FPU; a stray mdu_done must not complete it
        issue(1'b1, 1'b1, 1'b0, 1'b1, 5'd0);
        chk("prio_starts", {mdu_start, fpu_start}, 2'b01);
        mdu_done = 1'b1;
        step();
        mdu_done = 1'b0;
        chk("prio_ignore_mdu_done", wb_valid, 0);
        chk("prio_no_mdu_start", mdu_start, 0);
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("prio_wb", {wb_valid, wb_sel, wb_fp, wb_we}, {1'b1, 2'b10, 1'b0, 1'b0});
        step();

        // Reset during MDU_WAIT, then a late mdu_done
        issue(1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_ready", issue_ready, 1);
        chk("rstmid_outs", {mdu_start, fpu_start, wb_valid, timeout_err}, 0);
        mdu_done = 1'b1;
        step();
        mdu_done = 1'b0;
        chk("rstmid_late_done", wb_valid, 0);
        chk("rstmid_ready2", issue_ready, 1);
        step();

        // Done arriving on the last allowed WAIT cycle is a normal completion in every build
        issue(1'b0, 1'b1, 1'b0, 1'b1, 5'd6);
        step(); step(); step();
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("late_done_wb", {wb_valid, wb_we, timeout_err, wb_rd}, {1'b1, 1'b1, 1'b0, 5'd6});
        step();

        // FPU never completes
        issue(1'b0, 1'b1, 1'b0, 1'b1, 5'd2);
        wb_cyc = 0; to_bad = 0; to_s = 1'b0; we_s = 1'b0; sel_s = 2'b00;
        for (int c = 1; c <= 10; c++) begin
            if (timeout_err && !wb_valid) to_bad++;
            if (wb_valid) begin
                wb_cyc = c; to_s = timeout_err; we_s = wb_we; sel_s = wb_sel;
                break;
            end
            step();
        end
        chk("to_err_outside_wb", to_bad, 0);
`ifdef SCHED_TIMEOUT_EN
        chk("to_wb_cycle", wb_cyc, 5);
        chk("to_err", to_s, 1);
        chk("to_we", we_s, 0);
        chk("to_sel", sel_s, 2);
        step();
        chk("to_idle", {issue_ready, timeout_err, wb_valid}, 3'b100);
`else
        chk("hold_no_wb", wb_cyc, 0);
        chk("hold_stall", stall, 1);
        fpu_done = 1'b1;
        step();
        fpu_done = 1'b0;
        chk("hold_wb", {wb_valid, wb_we, timeout_err}, 3'b110);
        step();
        chk("hold_idle", issue_ready, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
